aes_192_ctrl: RTL and testbench
===============================

AES_192_CTRL -- requirements
Module: aes_192_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64; maximum cycles spent in ARM+WAIT before the watchdog fires.
REQ-002 Port clk  input  1  single clock; all logic SHALL be posedge clk.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port in_valid  input  1  request present; in_ready  output  1  request accepted when both high.
REQ-005 Port in_state  input  128  plaintext block; in_key  input  192  AES-192 key.
REQ-006 Port out_valid  output  1  result present; out_ready  input  1  result consumed when both high.
REQ-007 Port out_data  output  128  ciphertext; out_error  output  1  watchdog abort flag, valid with out_valid.
REQ-008 Port debug_mode  input  1  debug request; core_debug_mode  output  1  registered copy to core.
REQ-009 Port core_start  output  1; core_state  output  128; core_key  output  192; all registered, drive the core.
REQ-010 Port core_out  input  128; core_out_valid  input  1; core result and level-valid.

Function
REQ-011 FSM states SHALL be IDLE, START, ARM, WAIT, DONE.
REQ-012 IDLE: in_ready=1; on in_valid, latch in_state/in_key into core_state/core_key, go START.
REQ-013 START: core_start=1 for exactly one cycle, go ARM; core_start SHALL be 0 in every other state, guaranteeing a core rising edge per request.
REQ-014 ARM: wait for core_out_valid=0 (core counter reloaded), then go WAIT; stale high core_out_valid SHALL never be captured.
REQ-015 WAIT: on core_out_valid=1, capture core_out into out_data, out_error=0, go DONE.
REQ-016 DONE: out_valid=1, out_data/out_error stable; on out_ready go IDLE; in_ready=0.
REQ-017 in_ready SHALL be 1 only in IDLE with debug_mode=0; one request in flight maximum.
REQ-018 With core reload count 25, out_valid SHALL rise 28 cycles after the acceptance edge.
REQ-019 core_state/core_key SHALL hold constant from acceptance until return to IDLE.
REQ-020 debug_mode=1 in any state: next state IDLE, out_data cleared to 0, out_valid=0, core_key cleared to 0; no request accepted while high.
REQ-021 in_valid and out_ready simultaneously in DONE: out_ready handled, new request not accepted until IDLE next cycle.

Reset
REQ-022 rst=1: state IDLE, out_valid=0, out_error=0, out_data=0, core_start=0, core_state=0, core_key=0, core_debug_mode=0, watchdog count 0; rst overrides debug_mode.
REQ-023 rst mid-operation SHALL abandon the request with no out_valid pulse.

Configuration
REQ-024 Macro AES192_CTRL_TIMEOUT_EN defined: counter runs in ARM+WAIT; at TIMEOUT_CYCLES go DONE with out_error=1, out_data=0.
REQ-025 Macro undefined: no counter, out_error tied 0, WAIT waits indefinitely.

Structure
REQ-026 Shared package aes_192_ctrl_pkg SHALL hold the state enum, CORE_RELOAD=25, and default TIMEOUT_CYCLES.
REQ-027 Single flat module; no sub-module needed.

Verification
REQ-028 FIPS-197 AES-192 vector (key 000102..1617, pt 00112233..eeff) through real core -> out_data dda97ca4864cdfe06eaf70a0ec0d7191, out_valid at cycle 28.
REQ-029 out_ready held 0 for 10 cycles in DONE -> out_valid/out_data stable, in_ready=0 throughout.
REQ-030 Core model holding core_out_valid=1 before start -> no capture until it drops and rises again.
REQ-031 debug_mode pulsed at cycle 10 of WAIT -> IDLE next cycle, out_data=0, no out_valid.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=64, core never valid -> out_valid with out_error=1, out_data=0 after 64 cycles.
REQ-033 rst at cycle 5 of WAIT -> all outputs reset values next cycle; following request completes normally.

Source files
------------

// File: rtl/aes_192_ctrl_pkg.sv
// aes_192_ctrl_pkg: shared definitions for the AES-192 core controller.
//   ctrl_state_t           - controller FSM state encoding
//   CORE_RELOAD            - cycles the AES-192 core counts after a start
//   DEFAULT_TIMEOUT_CYCLES - default watchdog limit for ARM+WAIT
package aes_192_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    WAIT,
    DONE
  } ctrl_state_t;

  localparam int unsigned CORE_RELOAD            = 25;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/aes_192_ctrl.sv
// aes_192_ctrl: request/response wrapper around an iterative AES-192 core.
// Accepts one plaintext/key pair at a time, pulses core_start once, waits for
// the core's level-valid result (ignoring a stale high valid from the previous
// run) and holds the ciphertext until the consumer takes it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             request handshake
//   in_state[127:0], in_key[191:0] plaintext and AES-192 key
//   out_valid/out_ready           result handshake
//   out_data[127:0], out_error    ciphertext, watchdog abort flag
//   debug_mode, core_debug_mode   debug request in, registered copy to core
//   core_start, core_state, core_key  registered core drive
//   core_out[127:0], core_out_valid   core result, level valid
//
// Build option: define AES192_CTRL_TIMEOUT_EN to enable the ARM+WAIT watchdog
// (limit TIMEOUT_CYCLES); without it WAIT waits indefinitely and out_error is 0.
module aes_192_ctrl
  import aes_192_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [191:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_error,
  input  logic         debug_mode,
  output logic         core_debug_mode,
  output logic         core_start,
  output logic [127:0] core_state,
  output logic [191:0] core_key,
  input  logic [127:0] core_out,
  input  logic         core_out_valid
);

  ctrl_state_t state, state_nx;
  logic        accept;
  logic        capture;
  logic        timeout;

  assign in_ready  = (state == IDLE) && !debug_mode;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

`ifdef AES192_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;

  assign wd_run  = (state == ARM) || (state == WAIT);
  assign timeout = wd_run && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !wd_run) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nx = START;
      START: state_nx = ARM;
      // Leave ARM only once the core has dropped valid after its reload, so a
      // result left high from the previous request is never taken.
      ARM: begin
        if (timeout) begin
          state_nx = DONE;
        end else if (!core_out_valid) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (core_out_valid) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else if (timeout) begin
          state_nx = DONE;
        end
      end
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (debug_mode) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      out_data        <= '0;
      out_error       <= 1'b0;
      core_start      <= 1'b0;
      core_state      <= '0;
      core_key        <= '0;
      core_debug_mode <= 1'b0;
    end else begin
      state           <= state_nx;
      core_debug_mode <= debug_mode;
      // Registered start: high exactly while the FSM sits in START.
      core_start      <= (state_nx == START);
      if (debug_mode) begin
        out_data  <= '0;
        out_error <= 1'b0;
        core_key  <= '0;
      end else begin
        if (accept) begin
          core_state <= in_state;
          core_key   <= in_key;
        end
        if (capture) begin
          out_data  <= core_out;
          out_error <= 1'b0;
        end else if (timeout) begin
          out_data  <= '0;
          out_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_192_ctrl.sv
// tb_aes_192_ctrl: self-checking bench for aes_192_ctrl with a behavioural
// AES-192 core (reload counter, optional start lag, optional hang).
module tb_aes_192_ctrl;
  import aes_192_ctrl_pkg::*;

  localparam int unsigned TO  = 64;
  localparam int unsigned LAT = 28;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [191:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_error;
  logic         debug_mode = 1'b0;
  logic         core_debug_mode;
  logic         core_start;
  logic [127:0] core_state;
  logic [191:0] core_key;
  logic [127:0] core_out = 128'h0badc0de_0badc0de_0badc0de_0badc0de;
  logic         core_out_valid = 1'b1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [127:0] data;
    logic         err;
  } exp_t;
  exp_t sb[$];

  aes_192_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_error(out_error),
    .debug_mode(debug_mode), .core_debug_mode(core_debug_mode),
    .core_start(core_start), .core_state(core_state), .core_key(core_key),
    .core_out(core_out), .core_out_valid(core_out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES-192 reference ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes192(input logic [127:0] pt, input logic [191:0] key);
    logic [31:0]  w [52];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
               sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-6] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int rnd = 0; rnd <= 12; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
        if (rnd < 12) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
            s[4*c+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        tmp = w[4*rnd+c];
        s[4*c]   = s[4*c]   ^ tmp[31:24];
        s[4*c+1] = s[4*c+1] ^ tmp[23:16];
        s[4*c+2] = s[4*c+2] ^ tmp[15:8];
        s[4*c+3] = s[4*c+3] ^ tmp[7:0];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- behavioural core ----------------
  int unsigned  core_cnt = 0;
  int unsigned  core_lag_cnt = 0;
  int unsigned  core_lag = 0;
  bit           core_pend = 1'b0;
  bit           core_hang = 1'b0;
  logic [127:0] core_res = '0;

  always @(posedge clk) begin
    if (core_start === 1'b1) begin
      core_res <= aes192(core_state, core_key);
      if (core_lag == 0) begin
        core_cnt       <= CORE_RELOAD;
        core_out_valid <= 1'b0;
      end else begin
        core_pend    <= 1'b1;
        core_lag_cnt <= core_lag - 1;
      end
    end else if (core_pend) begin
      if (core_lag_cnt != 0) begin
        core_lag_cnt <= core_lag_cnt - 1;
      end else begin
        core_pend      <= 1'b0;
        core_cnt       <= CORE_RELOAD;
        core_out_valid <= 1'b0;
      end
    end else if (core_cnt != 0) begin
      core_cnt       <= core_cnt - 1;
      core_out_valid <= 1'b0;
    end else if (!core_hang) begin
      core_out_valid <= 1'b1;
      core_out       <= core_res;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] pt, input logic [191:0] key, output int unsigned acc);
    bit ok;
    ok = 1'b0;
    in_state = pt;
    in_key   = key;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    acc = cyc;
    checks++;
    if (!ok) begin
      $display("FAIL send_accept: in_ready stayed 0, expected 1 within 50 cycles");
      errors++;
    end
  endtask

  // Returns at the negedge where out_valid is first seen high.
  task automatic wait_valid(input int unsigned acc, input int unsigned lat,
                            input logic [127:0] pt, input logic [191:0] key, input string nm);
    bit seen;
    bit unstable;
    bit rdy_bad;
    int unsigned starts;
    seen = 1'b0; unstable = 1'b0; rdy_bad = 1'b0; starts = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (core_start === 1'b1) starts++;
      if (core_state !== pt || core_key !== key) unstable = 1'b1;
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL %s_valid: out_valid=0 after 200 cycles, expected 1", nm);
      errors++;
    end else begin
      checks++;
      if (cyc - acc !== lat) begin
        $display("FAIL %s_latency: got %0d expected %0d", nm, cyc - acc, lat);
        errors++;
      end
    end
    checks++;
    if (starts !== 1) begin
      $display("FAIL %s_start_pulse: got %0d core_start cycles expected 1", nm, starts);
      errors++;
    end
    checks++;
    if (unstable) begin
      $display("FAIL %s_core_hold: core_state/core_key changed, expected %h / %h", nm, pt, key);
      errors++;
    end
    checks++;
    if (rdy_bad) begin
      $display("FAIL %s_busy_ready: in_ready=1 while busy, expected 0", nm);
      errors++;
    end
  endtask

  // Called at a negedge with out_valid and out_ready high; returns #1 after the handshake edge.
  task automatic consume(input string nm);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s_scoreboard: result present, expected none queued", nm);
      errors++;
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_data !== e.data) begin
        $display("FAIL %s_data: got %h expected %h", nm, out_data, e.data);
        errors++;
      end
      checks++;
      if (out_error !== e.err) begin
        $display("FAIL %s_error: got %b expected %b", nm, out_error, e.err);
        errors++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL %s_drop: out_valid=%b after handshake, expected 0", nm, out_valid);
      errors++;
    end
  endtask

  task automatic quiet(input int unsigned n, input string nm);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      $display("FAIL %s_no_valid: out_valid pulsed, expected 0 for %0d cycles", nm, n);
      errors++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; debug_mode = 1'b1; in_valid = 1'b1; in_state = rnd128(); in_key = rnd192();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (core_debug_mode !== 1'b0) begin $display("FAIL rst_core_debug: got %b expected 0", core_debug_mode); errors++; end
    checks++; if (core_start !== 1'b0) begin $display("FAIL rst_core_start: got %b expected 0", core_start); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b expected 0", out_valid); errors++; end
    checks++; if (in_ready !== 1'b0) begin $display("FAIL rst_ready_dbg: got %b expected 0", in_ready); errors++; end
    @(posedge clk); #1;
    debug_mode = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %b expected 1", in_ready); errors++; end
    checks++; if (out_data !== '0) begin $display("FAIL rst_out_data: got %h expected 0", out_data); errors++; end
    checks++; if (out_error !== 1'b0) begin $display("FAIL rst_out_error: got %b expected 0", out_error); errors++; end
    checks++; if (core_state !== '0) begin $display("FAIL rst_core_state: got %h expected 0", core_state); errors++; end
    checks++; if (core_key !== '0) begin $display("FAIL rst_core_key: got %h expected 0", core_key); errors++; end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    logic [127:0] pt;
    logic [191:0] key;
    int unsigned  acc;
    pt  = 128'h00112233445566778899aabbccddeeff;
    key = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    out_ready = 1'b1;
    send(pt, key, acc);
    sb.push_back(exp_t'{data: 128'hdda97ca4864cdfe06eaf70a0ec0d7191, err: 1'b0});
    wait_valid(acc, LAT, pt, key, "fips");
    consume("fips");
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, pt2;
    logic [191:0] key, key2;
    int unsigned  acc;
    bit           bad;
    pt = rnd128(); key = rnd192(); pt2 = rnd128(); key2 = rnd192();
    out_ready = 1'b0;
    send(pt, key, acc);
    sb.push_back(exp_t'{data: aes192(pt, key), err: 1'b0});
    wait_valid(acc, LAT, pt, key, "bp");
    in_state = pt2; in_key = key2; in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== sb[0].data || in_ready !== 1'b0 || core_state !== pt) begin
        $display("FAIL bp_hold: valid=%b data=%h ready=%b expected valid=1 data=%h ready=0",
                 out_valid, out_data, in_ready, sb[0].data);
        errors++;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL bp_ready_in_done: got %b expected 0", in_ready); errors++; end
    consume("bp");
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL bp_ready_idle: got %b expected 1", in_ready); errors++; end
    checks++;
    if (core_state !== pt) begin $display("FAIL bp_no_early_accept: core_state %h expected %h", core_state, pt); errors++; end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    sb.push_back(exp_t'{data: aes192(pt2, key2), err: 1'b0});
    wait_valid(acc, LAT, pt2, key2, "bp2");
    consume("bp2");
  endtask

  task automatic test_stale();
    logic [127:0] pt;
    logic [191:0] key;
    int unsigned  acc;
    pt = rnd128(); key = rnd192();
    core_lag = 5;
    send(pt, key, acc);
    sb.push_back(exp_t'{data: aes192(pt, key), err: 1'b0});
    wait_valid(acc, LAT + 5, pt, key, "stale");
    consume("stale");
    core_lag = 0;
  endtask

  task automatic test_debug();
    logic [127:0] pt;
    logic [191:0] key;
    int unsigned  acc;
    bit           bad;
    pt = rnd128(); key = rnd192();
    send(pt, key, acc);
    repeat (11) @(posedge clk);
    #1;
    debug_mode = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin $display("FAIL dbg_ready_busy: got %b expected 0", in_ready); errors++; end
    @(posedge clk); #1;
    debug_mode = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin $display("FAIL dbg_out_valid: got %b expected 0", out_valid); errors++; end
    checks++; if (out_data !== '0) begin $display("FAIL dbg_out_data: got %h expected 0", out_data); errors++; end
    checks++; if (core_key !== '0) begin $display("FAIL dbg_core_key: got %h expected 0", core_key); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL dbg_idle_ready: got %b expected 1", in_ready); errors++; end
    checks++; if (core_debug_mode !== 1'b1) begin $display("FAIL dbg_core_debug: got %b expected 1", core_debug_mode); errors++; end
    @(posedge clk); #1;
    debug_mode = 1'b1; in_valid = 1'b1; in_state = rnd128(); in_key = rnd192();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || core_start !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    debug_mode = 1'b0; in_valid = 1'b0;
    checks++;
    if (bad) begin $display("FAIL dbg_block: request accepted while debug_mode=1, expected none"); errors++; end
    checks++;
    if (core_key !== '0) begin $display("FAIL dbg_block_key: core_key %h expected 0", core_key); errors++; end
    quiet(40, "dbg");
    checks++;
    if (sb.size() != 0) begin $display("FAIL dbg_scoreboard: %0d pending expected 0", sb.size()); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt;
    logic [191:0] key;
    int unsigned  acc;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      pt = rnd128(); key = rnd192();
      send(pt, key, acc);
      sb.push_back(exp_t'{data: aes192(pt, key), err: 1'b0});
      wait_valid(acc, LAT, pt, key, "b2b");
      consume("b2b");
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    logic [191:0] key;
    int unsigned  acc;
    pt = rnd128(); key = rnd192();
    send(pt, key, acc);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin $display("FAIL rmid_out_valid: got %b expected 0", out_valid); errors++; end
    checks++; if (out_data !== '0) begin $display("FAIL rmid_out_data: got %h expected 0", out_data); errors++; end
    checks++; if (out_error !== 1'b0) begin $display("FAIL rmid_out_error: got %b expected 0", out_error); errors++; end
    checks++; if (core_state !== '0) begin $display("FAIL rmid_core_state: got %h expected 0", core_state); errors++; end
    checks++; if (core_key !== '0) begin $display("FAIL rmid_core_key: got %h expected 0", core_key); errors++; end
    checks++; if (core_start !== 1'b0) begin $display("FAIL rmid_core_start: got %b expected 0", core_start); errors++; end
    checks++; if (in_ready !== 1'b1) begin $display("FAIL rmid_in_ready: got %b expected 1", in_ready); errors++; end
    quiet(40, "rmid");
    pt = rnd128(); key = rnd192();
    @(posedge clk); #1;
    send(pt, key, acc);
    sb.push_back(exp_t'{data: aes192(pt, key), err: 1'b0});
    wait_valid(acc, LAT, pt, key, "rmid_after");
    consume("rmid_after");
  endtask

`ifdef AES192_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [127:0] pt;
    logic [191:0] key;
    int unsigned  acc;
    pt = rnd128(); key = rnd192();
    core_hang = 1'b1;
    send(pt, key, acc);
    sb.push_back(exp_t'{data: '0, err: 1'b1});
    wait_valid(acc, TO + 1, pt, key, "timeout");
    consume("timeout");
    core_hang = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    test_reset();
    test_fips();
    test_backpressure();
    test_stale();
    test_debug();
    test_back_to_back();
    test_reset_mid();
`ifdef AES192_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL final_scoreboard: %0d results pending, expected 0", sb.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
